fb_write_scheduler: RTL

FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

---
 rtl/fb_write_scheduler.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/fb_write_scheduler.sv
// Framebuffer write scheduler: arbitrates the GPU write port of a double-
// buffered framebuffer between a back-buffer clear engine and the rasterizer,
// synchronised to the display buffer swap (falling edge of VGA vsync).
//
// Ports:
//   clk, reset              - system clock, synchronous active-high reset
//   vsync                   - raw vsync from the pixel-clock domain
//   clear_en, clear_color   - enable and fill colour for the per-frame clear
//   rast_req/addr/data      - rasterizer write request
//   rast_ready              - write accepted when rast_req & rast_ready
//   frame_done              - rasterizer has finished the current frame
//   frame_start             - pulse: back buffer is ready for drawing
//   wea, addra, dina        - registered framebuffer write port
//   state_o                 - current state (WAIT_SWAP=0, CLEAR=1, DRAW=2)
//   overrun_cnt             - frames abandoned at a swap, saturating at 255
// FB_PIXELS must not exceed 2**ADDR_WIDTH.
module fb_write_scheduler #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned FB_PIXELS  = 76800
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vsync,
  input  logic                  clear_en,
  input  logic [7:0]            clear_color,
  input  logic                  rast_req,
  input  logic [ADDR_WIDTH-1:0] rast_addr,
  input  logic [7:0]            rast_data,
  output logic                  rast_ready,
  input  logic                  frame_done,
  output logic                  frame_start,
  output logic                  wea,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [7:0]            dina,
  output logic [1:0]            state_o,
  output logic [7:0]            overrun_cnt
);

  localparam logic [ADDR_WIDTH:0]   PIX_LIMIT = (ADDR_WIDTH+1)'(FB_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_WAIT_SWAP = 2'd0,
    ST_CLEAR     = 2'd1,
    ST_DRAW      = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  prev_q, prev_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]            color_q, color_d;
  logic                  wea_q, wea_d;
  logic [ADDR_WIDTH-1:0] addra_q, addra_d;
  logic [7:0]            dina_q, dina_d;
  logic                  rast_ready_q, rast_ready_d;
  logic                  frame_start_q, frame_start_d;
  logic [7:0]            overrun_q, overrun_d;

  logic swap_edge;
  logic swap_next;
  logic accept;
  logic in_range;
  logic go_clear;
  logic go_draw;

  // swap_edge coincides with the framebuffer toggling its buffers; swap_next
  // is the value swap_edge will take next cycle, so rast_ready can be a flop.
  assign swap_edge = prev_q & ~sync2_q;
  assign swap_next = sync2_q & ~sync1_q;
  assign accept    = rast_req & rast_ready_q & ~swap_edge;
  assign in_range  = ({1'b0, rast_addr} < PIX_LIMIT);

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    sync1_d       = vsync;
    sync2_d       = sync1_q;
    prev_d        = sync2_q;
    cnt_d         = cnt_q;
    color_d       = color_q;
    wea_d         = 1'b0;
    addra_d       = addra_q;
    dina_d        = dina_q;
    frame_start_d = 1'b0;
    overrun_d     = overrun_q;
    go_clear      = 1'b0;
    go_draw       = 1'b0;

    unique case (state_q)
      ST_WAIT_SWAP: begin
        if (swap_edge) begin
          go_clear = clear_en;
          go_draw  = ~clear_en;
        end
      end

      ST_CLEAR: begin
        if (swap_edge) begin
          // Clear did not finish before the swap: start over on the new buffer.
          if (overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
          go_clear = 1'b1;
        end else if (cnt_q == LAST_ADDR) begin
          state_d       = ST_DRAW;
          frame_start_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + ONE_ADDR;
          wea_d   = 1'b1;
          addra_d = cnt_q + ONE_ADDR;
          dina_d  = color_q;
        end
      end

      ST_DRAW: begin
        if (accept && in_range) begin
          wea_d   = 1'b1;
          addra_d = rast_addr;
          dina_d  = rast_data;
        end
        if (swap_edge) begin
          if (!frame_done && (overrun_q != 8'hFF)) overrun_d = overrun_q + 8'd1;
          go_clear = clear_en;
          go_draw  = ~clear_en;
        end else if (frame_done) begin
          state_d = ST_WAIT_SWAP;
        end
      end

      default: state_d = ST_WAIT_SWAP;
    endcase

    // Frame start: the clear issues address 0 on its entry edge.
    if (go_clear) begin
      state_d = ST_CLEAR;
      color_d = clear_color;
      cnt_d   = '0;
      wea_d   = 1'b1;
      addra_d = '0;
      dina_d  = clear_color;
    end else if (go_draw) begin
      state_d       = ST_DRAW;
      frame_start_d = 1'b1;
    end

    rast_ready_d = (state_d == ST_DRAW) & ~swap_next;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_WAIT_SWAP;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      prev_q        <= 1'b0;
      cnt_q         <= '0;
      color_q       <= 8'd0;
      wea_q         <= 1'b0;
      addra_q       <= '0;
      dina_q        <= 8'd0;
      rast_ready_q  <= 1'b0;
      frame_start_q <= 1'b0;
      overrun_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      color_q       <= color_d;
      wea_q         <= wea_d;
      addra_q       <= addra_d;
      dina_q        <= dina_d;
      rast_ready_q  <= rast_ready_d;
      frame_start_q <= frame_start_d;
      overrun_q     <= overrun_d;
    end
  end

  assign rast_ready  = rast_ready_q;
  assign frame_start = frame_start_q;
  assign wea         = wea_q;
  assign addra       = addra_q;
  assign dina        = dina_q;
  assign state_o     = state_q;
  assign overrun_cnt = overrun_q;

endmodule
